// File: rtl/dividend_rebuild_if.sv
// Operand/result bundle for dividend_rebuild: start + quo/divisor/rem in, busy/done/result/err out.
// Latency: none (wires only).
// Backpressure: none; the requester watches busy/done and only pulses start when the block is free.
interface dividend_rebuild_if;
  logic        start;
  logic [8:0]  quo;
  logic [15:0] divisor;
  logic [8:0]  rem;
  logic        busy;
  logic        done;
  logic [25:0] result;
  logic        err;

  modport master (
    output start, quo, divisor, rem,
    input  busy, done, result, err
  );

  modport slave (
    input  start, quo, divisor, rem,
    output busy, done, result, err
  );
endinterface

// File: rtl/dividend_rebuild.sv
// Rebuilds a dividend as quo * divisor + rem with a shift-add loop, one quotient bit per clock.
// Latency: result/done 9 edges after the accept edge; one op per 10 cycles.
// Backpressure: start is honoured only when free (IDLE, or the edge that ends DONE); otherwise dropped.
// Optional DIVIDEND_REBUILD_REM_CHECK_EN: err flags rem >= divisor alongside done.
module dividend_rebuild (
  input  logic                clk,
  input  logic                rst_n,
  dividend_rebuild_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  sreg_q, sreg_d;
  logic [25:0] acc_q, acc_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [25:0] result_q, result_d;
  logic        load;

  // Divisor weighted by the current quotient bit position, and the accumulator after this step.
  logic [25:0] addend;
  logic [25:0] acc_step;
  assign addend   = {10'd0, div_q} << cnt_q;
  assign acc_step = sreg_q[0] ? (acc_q + addend) : acc_q;

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      acc_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      acc_q    <= acc_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath: load operands on accept, run 9 steps, publish result on the last.
  // The edge that leaves DONE also acts as an IDLE edge for start, so a held start
  // restarts immediately and back-to-back operations complete every 10 cycles.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    acc_d    = acc_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_step;
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          result_d = acc_step;
          state_d  = DONE;
        end
      end
      DONE: begin
        load    = bus.start;
        state_d = bus.start ? CALC : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      div_d  = bus.divisor;
      sreg_d = bus.quo;
      acc_d  = {17'd0, bus.rem};
      cnt_d  = 4'd0;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

`ifdef DIVIDEND_REBUILD_REM_CHECK_EN
  logic flag_q, flag_d;
  logic err_q, err_d;
  logic last_step;

  assign last_step = (state_q == CALC) && (cnt_q == 4'd8);

  // Range flag captured with the operands; exposed only for the done cycle.
  always_comb begin
    flag_d = flag_q;
    err_d  = err_q;
    if (load) begin
      flag_d = ({7'd0, bus.rem} >= bus.divisor);
    end
    if (last_step) begin
      err_d = flag_q;
    end else if (state_q == DONE) begin
      err_d = 1'b0;
    end
  end

  // Range-flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
